clkdiv_multi: RTL and testbench
===============================

// Module: clkdiv_multi
// PURPOSE
//   Multi-channel programmable clock/tick divider: successor to the single-ratio divider.
//   N_CH independent channels, each with a runtime-loadable divide ratio, registered
//   clkdiv output and one-cycle tick strobe. Feeds timers, scan/blink logic, baud sources.
//   Ratio updates are glitch-free: applied only at a period boundary.
// PARAMETERS
//   N_CH        4           number of divider channels (1..16)
//   DIV_W       26          width of divide ratio and counters
//   DEFAULT_DIV 50_000_000  ratio loaded into every channel at reset (>=2, < 2**DIV_W)
// PORTS
//   clk       in   1            system clock
//   rst       in   1            asynchronous, active-high reset
//   en        in   N_CH         per-channel run enable
//   cfg_we    in   1            write strobe for ratio shadow register
//   cfg_ch    in   $clog2(N_CH) channel index for write (width 1 when N_CH=1)
//   cfg_div   in   DIV_W        new divide ratio
//   sync      in   1            phase-align pulse (used only with CLKDIV_SYNC_EN)
//   clkdiv    out  N_CH         registered divided clock per channel
//   tick      out  N_CH         one-cycle pulse at start of each period
// BEHAVIOUR
//   - Per channel i: cnt[i] (DIV_W), active ratio div_act[i], shadow div_sh[i].
//   - Reset (async): cnt=0, div_act=div_sh=DEFAULT_DIV, clkdiv=0, tick=0.
//   - Config: on cfg_we, div_sh[cfg_ch] <= cfg_div; cfg_div 0 or 1 stored as 2;
//     cfg_ch >= N_CH ignored. Back-to-back writes: last write wins.
//   - Run (en[i]=1): cnt counts 0..div_act-1 then wraps to 0. At wrap
//     (cnt==div_act-1) div_act <= div_sh; the new ratio governs the next period.
//   - clkdiv[i] registered, high exactly while cnt[i] >= (div_act[i]>>1), aligned with
//     cnt. Even ratio: 50% duty. Odd ratio: high one cycle longer (div=5 -> 0,0,1,1,1).
//   - tick[i] registered, high for one cycle in each cycle where cnt[i]==0 having
//     followed a wrap or sync; not asserted on the first cycle after enable or reset.
//   - en[i]=0: next cycle cnt=0, clkdiv=0, tick=0, div_act <= div_sh (immediate apply).
//     en 0->1: first enabled cycle has cnt=0, clkdiv=0; first tick after first wrap.
//   - Channels fully independent; no cross-channel priority or interaction.
//   - cfg_we in the same cycle as a wrap on that channel: div_act takes the OLD
//     shadow; new value applies at the following wrap.
//   - Reset mid-period: async clear per reset values, incl. div regs -> DEFAULT_DIV.
//   - No combinational path from any input to clkdiv/tick.
// CONFIGURATION
//   CLKDIV_SYNC_EN defined: sync=1 forces cnt=0 on every enabled channel next cycle,
//     applies div_sh, and asserts tick; sync has priority over wrap and config apply.
//     Disabled channels are unaffected.
//   Not defined: sync port present but ignored; no sync logic synthesised.
// TESTING
//   1. Reset, DEFAULT_DIV=4, en=4'b0001 -> clkdiv[0] 0,0,1,1 repeating; tick[0] every 4
//      cycles, first tick 4 cycles after enable; other channels stay 0.
//   2. ch0 at div=4, write cfg_div=5 at cnt=1 -> current period ends at 4 cycles, then
//      0,0,1,1,1 periods; tick spacing 4 then 5.
//   3. Write cfg_div=1 and cfg_div=0 -> stored 2; clkdiv toggles 0,1 each cycle, tick every 2.
//   4. Drop en[0] at cnt=2 -> next cycle clkdiv[0]=0, tick[0]=0; re-enable -> restart at cnt=0.
//   5. Assert rst mid-period with div=7 -> outputs 0 immediately; after release div=DEFAULT_DIV.
//   6. CLKDIV_SYNC_EN, ch0 div=4, ch1 div=6 out of phase, pulse sync -> both ticks next
//      cycle together; without macro, sync has no effect.

Source files
------------

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock/tick divider with glitch-free ratio updates at period boundaries.
// Optional feature macro: CLKDIV_SYNC_EN (sync pulse phase-aligns every enabled channel).
module clkdiv_multi #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 26,
    parameter int DEFAULT_DIV = 50_000_000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_CH-1:0]                       en,
    input  logic                                  cfg_we,
    input  logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]                      cfg_div,
    input  logic                                  sync,
    output logic [N_CH-1:0]                       clkdiv,
    output logic [N_CH-1:0]                       tick
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

    logic sync_hit;

`ifdef CLKDIV_SYNC_EN
    assign sync_hit = sync;
`else
    logic unused_sync;
    assign unused_sync = sync;
    assign sync_hit    = 1'b0;
`endif

    // Ratios below 2 cannot form a period with both a low and a high phase.
    logic [DIV_W-1:0] cfg_div_sat;
    assign cfg_div_sat = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [DIV_W-1:0] cnt, div_act, div_sh;
        logic [DIV_W-1:0] cnt_nxt, act_nxt;
        logic             tick_nxt, wrap, sh_we;
        logic             clk_q, tick_q;

        // Indices >= N_CH never match any channel and are dropped.
        assign sh_we = cfg_we && (32'(cfg_ch) == 32'(g));
        assign wrap  = (cnt == div_act - DIV_W'(1));

        always_comb begin
            cnt_nxt  = cnt + DIV_W'(1);
            act_nxt  = div_act;
            tick_nxt = 1'b0;
            if (!en[g]) begin
                cnt_nxt = '0;
                act_nxt = div_sh;
            end else if (sync_hit || wrap) begin
                cnt_nxt  = '0;
                act_nxt  = div_sh;
                tick_nxt = 1'b1;
            end
        end

        // clkdiv is derived from next-state values so it lines up with cnt, not a cycle late.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt     <= '0;
                div_act <= DIV_RST;
                div_sh  <= DIV_RST;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                cnt     <= cnt_nxt;
                div_act <= act_nxt;
                clk_q   <= (cnt_nxt >= (act_nxt >> 1));
                tick_q  <= tick_nxt;
                if (sh_we)
                    div_sh <= cfg_div_sat;
            end
        end

        assign clkdiv[g] = clk_q;
        assign tick[g]   = tick_q;
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed, table-driven bench for clkdiv_multi (N_CH=4, DIV_W=8, DEFAULT_DIV=4).
module tb_clkdiv_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] en = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       sync = 1'b0;
    logic [3:0] clkdiv, tick;

    int tests = 0;
    int fails = 0;

    clkdiv_multi #(.N_CH(4), .DIV_W(8), .DEFAULT_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .sync(sync), .clkdiv(clkdiv), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] en;
        logic       we;
        logic [1:0] ch;
        logic [7:0] div;
        logic [3:0] exp_clk;
        logic [3:0] exp_tick;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] e, logic w, logic [1:0] c, logic [7:0] d,
                                logic [3:0] xc, logic [3:0] xt);
        vec_t v;
        v.en = e; v.we = w; v.ch = c; v.div = d; v.exp_clk = xc; v.exp_tick = xt;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [3:0] e, input logic w, input logic [1:0] c,
                        input logic [7:0] d, input logic s);
        @(negedge clk);
        en = e; cfg_we = w; cfg_ch = c; cfg_div = d; sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = '0; cfg_we = 1'b0; sync = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // test 1: default ratio 4
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0001));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0000));
        // test 2: write 5 at cnt=1
        vecs.push_back(mk(4'b0001, 1, 0, 5, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0001));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0001));
        // test 3: writes of 1 then 0 -> ratio 2
        vecs.push_back(mk(4'b0001, 1, 0, 1, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0001, 1, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0001));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0001));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0001));
        // write 4, then write 6 in the wrap cycle: old shadow (4) applies first
        vecs.push_back(mk(4'b0001, 1, 0, 4, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 1, 0, 6, 4'b0000, 4'b0001));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0001));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0000));
        // test 4: drop enable at cnt=2, then restart from 0 with ratio 6
        vecs.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0001, 4'b0000));
        vecs.push_back(mk(4'b0001, 0, 0, 0, 4'b0000, 4'b0001));

        repeat (2) @(posedge clk);
        #1;
        check("reset_clkdiv", clkdiv, 4'b0000);
        check("reset_tick", tick, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].we, vecs[i].ch, vecs[i].div, 1'b0);
            check($sformatf("vec%0d_clkdiv", i), clkdiv, vecs[i].exp_clk);
            check($sformatf("vec%0d_tick", i), tick, vecs[i].exp_tick);
        end

        // test 5: ch1 at ratio 7, reset mid-period, comes back at ratio 4
        do_reset();
        step(4'b0000, 1, 1, 7, 1'b0);
        step(4'b0000, 0, 0, 0, 1'b0);
        for (int k = 0; k < 4; k++) step(4'b0010, 0, 0, 0, 1'b0);
        check("div7_cnt4_clkdiv", clkdiv, 4'b0010);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_clkdiv", clkdiv, 4'b0000);
        check("async_rst_tick", tick, 4'b0000);
        en = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(4'b0010, 0, 0, 0, 1'b0);
            check($sformatf("post_rst%0d_clkdiv", k), clkdiv, (k == 1 || k == 2) ? 4'b0010 : 4'b0000);
            check($sformatf("post_rst%0d_tick", k), tick, (k == 3) ? 4'b0010 : 4'b0000);
        end

        // test 6: ch0 ratio 4, ch1 ratio 6, out of phase; pulse sync
        do_reset();
        step(4'b0000, 1, 1, 6, 1'b0);
        step(4'b0000, 0, 0, 0, 1'b0);
        step(4'b0001, 0, 0, 0, 1'b0);
        step(4'b0011, 0, 0, 0, 1'b0);
        step(4'b0011, 0, 0, 0, 1'b1);
`ifdef CLKDIV_SYNC_EN
        check("sync_tick", tick, 4'b0011);
        check("sync_clkdiv", clkdiv, 4'b0000);
        step(4'b0011, 0, 0, 0, 1'b0);
        check("sync_after_tick", tick, 4'b0000);
        check("sync_after_clkdiv", clkdiv, 4'b0000);
`else
        check("nosync_tick", tick, 4'b0000);
        check("nosync_clkdiv", clkdiv, 4'b0001);
        step(4'b0011, 0, 0, 0, 1'b0);
        check("nosync_after_tick", tick, 4'b0001);
        check("nosync_after_clkdiv", clkdiv, 4'b0010);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
